// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding and
// stream framing sizes.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StDone,
    StError
  } loader_state_e;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_CNT_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_valid_o flags the byte that
// completes a word, with word_o already including that byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [BYTE_CNT_W-1:0] LastIdx = BYTE_CNT_W'(WORD_BYTES - 1);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]           sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_en_i) begin
      cnt_d = cnt_q + 1'b1;
      sr_d  = {sr_q[15:0], byte_i};
    end
  end

  assign word_o       = {sr_q, byte_i};
  assign word_valid_o = byte_en_i && (cnt_q == LastIdx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Writer side of instruction memory: parses a length-prefixed byte stream into
// big-endian words and holds the CPU in reset until the load completes.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CmpW = CNT_WIDTH + 1;
  localparam logic [CmpW-1:0] Depth = CmpW'(1) << ADDR_WIDTH;

  loader_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d, hdr_full;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d, word_cnt_inc;
  logic                  last_q, last_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  accept, pack_clear, pack_en, word_valid;
  logic [31:0]           packed_word;

  assign accept       = in_valid && in_ready_q;
  assign pack_en      = accept && (state_q == StData) && !last_q;
  assign hdr_full     = n_q | CNT_WIDTH'(in_data);
  assign word_cnt_inc = word_cnt_q + (ADDR_WIDTH + 1)'(1);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pack_clear),
    .byte_en_i    (pack_en),
    .byte_i       (in_data),
    .word_o       (packed_word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    word_cnt_d  = word_cnt_q;
    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pack_clear  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StHdrHi;
      end
      StHdrHi: begin
        if (accept) begin
          n_d     = CNT_WIDTH'(in_data) << (8 * (HDR_BYTES - 1));
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          n_d = hdr_full;
          if (hdr_full == '0) begin
            state_d = StDone;
          end else if (CmpW'(hdr_full) > Depth) begin
            state_d = StError;
          end else begin
            word_cnt_d = '0;
            last_d     = 1'b0;
            pack_clear = 1'b1;
            state_d    = StData;
          end
        end
      end
      StData: begin
        // The last write has been issued; one extra cycle before DONE keeps
        // done/cpu_rst release two cycles after the final byte.
        if (last_q) begin
          last_d  = 1'b0;
          state_d = StDone;
        end else if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
          mem_wdata_d = packed_word;
          word_cnt_d  = word_cnt_inc;
          if (CmpW'(word_cnt_inc) == CmpW'(n_q)) last_d = 1'b1;
        end
      end
      StDone, StError: begin
        if (start) state_d = StHdrHi;
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = ((state_d == StHdrHi) || (state_d == StHdrLo) || (state_d == StData)) &&
                 !last_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      word_cnt_q  <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StError);

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory; the instruction fetcher is the reader side.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the processor (program counter) in reset until the load completes.

Parameters:
- ADDR_WIDTH, 10, word-address width of instruction memory; depth = 2^ADDR_WIDTH words.
- CNT_WIDTH, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  32  instruction word for the write.
- cpu_rst  output  1  reset to program_counter; high while loading.
- done  output  1  load finished successfully; level signal.
- err  output  1  header word count exceeds memory depth; level signal.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, state=IDLE.
- Byte transfer occurs only on a rising clk with in_valid=1 and in_ready=1. in_ready is a registered function of state.
- Stream format:
  - Header of 2 bytes, MSB first, giving word count N.
  - Followed by 4*N data bytes.
  - Each word is big-endian: first byte goes to [31:24], last byte to [7:0].
- FSM states:
  - IDLE: in_ready=0, cpu_rst=1. start -> HDR_HI.
  - HDR_HI: in_ready=1. Accepted byte -> N[15:8]. Next state HDR_LO.
  - HDR_LO: in_ready=1. Accepted byte -> N[7:0]. Then:
    - if N=0 -> DONE.
    - else if N > 2^ADDR_WIDTH -> ERROR.
    - else clear byte counter and word counter -> DATA.
  - DATA: in_ready=1.
    - Each accepted byte shifts into the assembly register and increments the 2-bit byte counter.
    - On acceptance of byte 3, the next cycle drives mem_we=1, mem_wdata = assembled word, mem_addr = word counter. The word counter then increments.
    - In that write cycle in_ready stays 1; a byte accepted in the same cycle starts the next word.
    - After the write of word N-1 -> DONE. in_ready drops in the cycle mem_we is asserted for that last word.
  - DONE: done=1, cpu_rst=0, in_ready=0. start -> HDR_HI, clearing done and setting cpu_rst=1 in the next cycle.
  - ERROR: err=1, cpu_rst=1, in_ready=0, no writes. start -> HDR_HI, clearing err.
- start is ignored in HDR_HI, HDR_LO and DATA.
- Latency: the last data byte is accepted in cycle T; mem_we is asserted in T+1; done=1 and cpu_rst=0 in T+2.
- Idle stream: in_valid low stalls the FSM indefinitely with no timeout.
- mem_we is a one-cycle pulse. mem_addr and mem_wdata hold their last values between writes.
- Word counter is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH is legal. The final write goes to address 2^ADDR_WIDTH - 1 with no wrap.
- Asynchronous reset mid-load returns to IDLE immediately:
  - mem_we deasserts at once and cpu_rst=1.
  - Words already written stay in memory.

Decomposition:
- Shared package loader_pkg:
  - state encoding enum for IDLE/HDR_HI/HDR_LO/DATA/DONE/ERROR;
  - header byte count constant HDR_BYTES=2;
  - WORD_BYTES=4.
- One natural sub-module, byte_packer: 8-to-32 shift register with 2-bit byte counter and word_valid pulse. The FSM, counters and memory interface stay in instruction_loader.

Test Plan:
- N=1, bytes 00 01 | 8C 01 00 04 with in_valid held high -> exactly one mem_we pulse with mem_addr=0 and mem_wdata=0x8C010004; done=1 and cpu_rst=0 two cycles after the last byte.
- N=3 with in_valid toggling every other cycle, words 0x11111111, 0x22222222, 0x33333333 -> writes at addresses 0,1,2 in order with those values; no extra pulses; in_ready=0 after completion.
- Header 00 00 -> no mem_we; done=1 and cpu_rst=0 one cycle after the second header byte.
- ADDR_WIDTH=10, header 04 01 (N=1025) -> err=1, cpu_rst stays 1, no mem_we, in_ready=0; a later start followed by header 00 00 clears err and sets done.
- rst asserted after 2 of N=4 words have been written -> outputs return to reset values asynchronously, FSM in IDLE; after start a full reload of N=4 writes addresses 0..3.
- start pulsed during DATA -> ignored, word counter unchanged; start pulsed in DONE -> cpu_rst=1 and done=0 the next cycle, new header accepted.
